// File: rtl/watch_pkg.sv
// Shared types and constants for the watch timekeeper: mode states,
// blank-field codes, field limits and a wrapping increment helper.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } watch_state_t;

  localparam logic [1:0] BLANK_NONE = 2'b00;
  localparam logic [1:0] BLANK_SEC  = 2'b01;
  localparam logic [1:0] BLANK_MIN  = 2'b10;
  localparam logic [1:0] BLANK_HOUR = 2'b11;

  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HOUR_MAX = 7'd23;

  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max_v);
    return (v >= max_v) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [1:0] field_code(input watch_state_t s);
    case (s)
      ST_SET_HOUR: return BLANK_HOUR;
      ST_SET_MIN:  return BLANK_MIN;
      ST_SET_SEC:  return BLANK_SEC;
      default:     return BLANK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer for an asynchronous debounced key, followed by a
// one-cycle rising-edge pulse.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/watch_timekeeper.sv
// HMS timekeeper with a 1 Hz prescaler, a four-state mode/set FSM driven by
// two keys, and a blink generator that blanks the field being set.
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [6:0] hour,
  output logic [1:0] blank_sel,
  output logic       tick_1hz
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  logic w_mode_edge;
  logic w_inc_edge;

  key_edge u_key_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key   (key_mode),
    .o_pulse (w_mode_edge)
  );

  key_edge u_key_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key   (key_inc),
    .o_pulse (w_inc_edge)
  );

  watch_state_t    r_state,     w_nxt_state;
  logic [6:0]      r_sec,       w_nxt_sec;
  logic [6:0]      r_min,       w_nxt_min;
  logic [6:0]      r_hour,      w_nxt_hour;
  logic [PW-1:0]   r_presc,     w_nxt_presc;
  logic            r_tick,      w_nxt_tick;
  logic [BW-1:0]   r_blink_cnt, w_nxt_blink_cnt;
  logic            r_blink_off, w_nxt_blink_off;
  logic [1:0]      r_blank,     w_nxt_blank;
  logic            w_inc_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_sec       <= '0;
      r_min       <= '0;
      r_hour      <= '0;
      r_presc     <= '0;
      r_tick      <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
      r_blank     <= BLANK_NONE;
    end else begin
      r_state     <= w_nxt_state;
      r_sec       <= w_nxt_sec;
      r_min       <= w_nxt_min;
      r_hour      <= w_nxt_hour;
      r_presc     <= w_nxt_presc;
      r_tick      <= w_nxt_tick;
      r_blink_cnt <= w_nxt_blink_cnt;
      r_blink_off <= w_nxt_blink_off;
      r_blank     <= w_nxt_blank;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_sec       = r_sec;
    w_nxt_min       = r_min;
    w_nxt_hour      = r_hour;
    w_nxt_presc     = '0;
    w_nxt_tick      = 1'b0;
    w_nxt_blink_cnt = r_blink_cnt;
    w_nxt_blink_off = r_blink_off;
    w_nxt_blank     = BLANK_NONE;
    w_inc_accept    = 1'b0;

    // r_tick is only ever high in RUN, so time advances only there.
    if (r_tick) begin
      w_nxt_sec = wrap_inc(r_sec, SEC_MAX);
      if (r_sec == SEC_MAX) begin
        w_nxt_min = wrap_inc(r_min, MIN_MAX);
        if (r_min == MIN_MAX) begin
          w_nxt_hour = wrap_inc(r_hour, HOUR_MAX);
        end
      end
    end

    // A mode edge takes priority; a coincident inc edge is dropped.
    if (w_mode_edge) begin
      case (r_state)
        ST_RUN:      w_nxt_state = ST_SET_HOUR;
        ST_SET_HOUR: w_nxt_state = ST_SET_MIN;
        ST_SET_MIN:  w_nxt_state = ST_SET_SEC;
        ST_SET_SEC:  w_nxt_state = ST_RUN;
        default:     w_nxt_state = ST_RUN;
      endcase
    end else if (w_inc_edge) begin
      case (r_state)
        ST_SET_HOUR: begin
          w_nxt_hour   = wrap_inc(r_hour, HOUR_MAX);
          w_inc_accept = 1'b1;
        end
        ST_SET_MIN: begin
          w_nxt_min    = wrap_inc(r_min, MIN_MAX);
          w_inc_accept = 1'b1;
        end
        ST_SET_SEC: begin
          w_nxt_sec    = wrap_inc(r_sec, SEC_MAX);
          w_inc_accept = 1'b1;
        end
        default: ;
      endcase
    end

    // Prescaler runs only while staying in RUN; entering RUN restarts it at 0.
    if (r_state == ST_RUN && w_nxt_state == ST_RUN) begin
      w_nxt_presc = (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
      w_nxt_tick  = (w_nxt_presc == PRESC_MAX);
    end

    if (w_nxt_state != r_state || w_inc_accept) begin
      w_nxt_blink_cnt = '0;
      w_nxt_blink_off = 1'b0;
    end else if (r_blink_cnt == BLINK_MAX) begin
      w_nxt_blink_cnt = '0;
      w_nxt_blink_off = ~r_blink_off;
    end else begin
      w_nxt_blink_cnt = r_blink_cnt + 1'b1;
    end

    if (w_nxt_blink_off) begin
      w_nxt_blank = field_code(w_nxt_state);
    end
  end

  assign sec       = r_sec;
  assign min       = r_min;
  assign hour      = r_hour;
  assign blank_sel = r_blank;
  assign tick_1hz  = r_tick;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Scoreboard bench for watch_timekeeper at CLK_HZ=10, BLINK_HZ=1.
module tb_watch_timekeeper;
  import watch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic [6:0] sec, min, hour;
  logic [1:0] blank_sel;
  logic       tick_1hz;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [6:0] s;
    logic [6:0] m;
    logic [6:0] h;
    logic [1:0] b;
  } exp_t;

  exp_t exp_q[$];

  watch_timekeeper #(.CLK_HZ(10), .BLINK_HZ(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .blank_sel (blank_sel),
    .tick_1hz  (tick_1hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int s, input int m, input int h,
                          input logic [1:0] b);
    exp_t e;
    e.tag = tag;
    e.s   = 7'(s);
    e.m   = 7'(m);
    e.h   = 7'(h);
    e.b   = b;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, ".sec"},   32'(sec),       32'(e.s));
    check({e.tag, ".min"},   32'(min),       32'(e.m));
    check({e.tag, ".hour"},  32'(hour),      32'(e.h));
    check({e.tag, ".blank"}, 32'(blank_sel), 32'(e.b));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_keys(input logic m, input logic i);
    key_mode = m;
    key_inc  = i;
    step(3);
  endtask

  task automatic tap_mode();
    drive_keys(1'b1, 1'b0);
    drive_keys(1'b0, 1'b0);
  endtask

  task automatic tap_inc(input int n);
    repeat (n) begin
      drive_keys(1'b0, 1'b1);
      drive_keys(1'b0, 1'b0);
    end
  endtask

  // Pulses reset between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    push_exp({tag, ".rst"}, 0, 0, 0, BLANK_NONE);
    pop_cmp();
    check({tag, ".rst.tick"}, 32'(tick_1hz), 32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    step(2);

    // Reset, first tick latency, tick period and minute carry
    do_reset("s1");
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (tick_1hz) begin
        k = i;
        break;
      end
    end
    check("s1.first_tick_edge", 32'(k), 32'd9);
    check("s1.sec_during_tick", 32'(sec), 32'd0);
    push_exp("s1.sec1", 1, 0, 0, BLANK_NONE);
    step(1);
    pop_cmp();
    check("s1.tick_one_cycle", 32'(tick_1hz), 32'd0);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (tick_1hz) begin
        k = i;
        break;
      end
    end
    check("s1.tick_period", 32'(k + 1), 32'd10);
    push_exp("s1.sec59", 59, 0, 0, BLANK_NONE);
    step(571);
    pop_cmp();
    push_exp("s1.min_carry", 0, 1, 0, BLANK_NONE);
    step(10);
    pop_cmp();

    // Mode sequencing and blink
    step(1);
    do_reset("s2");
    key_mode = 1'b1;
    step(3);
    push_exp("s2.set_hour", 0, 0, 0, BLANK_NONE);
    pop_cmp();
    for (int i = 0; i < 5; i++) begin
      check("s2.blink_on_hour", 32'(blank_sel), 32'(BLANK_NONE));
      check("s2.no_tick", 32'(tick_1hz), 32'd0);
      step(1);
    end
    for (int i = 0; i < 5; i++) begin
      check("s2.blink_off_hour", 32'(blank_sel), 32'(BLANK_HOUR));
      check("s2.no_tick", 32'(tick_1hz), 32'd0);
      step(1);
    end
    check("s2.blink_on_again", 32'(blank_sel), 32'(BLANK_NONE));
    drive_keys(1'b0, 1'b0);
    drive_keys(1'b1, 1'b0);
    check("s2.min_visible", 32'(blank_sel), 32'(BLANK_NONE));
    step(5);
    check("s2.min_code", 32'(blank_sel), 32'(BLANK_MIN));
    drive_keys(1'b0, 1'b0);
    drive_keys(1'b1, 1'b0);
    check("s2.sec_visible", 32'(blank_sel), 32'(BLANK_NONE));
    step(5);
    check("s2.sec_code", 32'(blank_sel), 32'(BLANK_SEC));
    drive_keys(1'b0, 1'b0);
    drive_keys(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("s2.run_steady", 32'(blank_sel), 32'(BLANK_NONE));
      step(1);
    end
    key_mode = 1'b0;

    // Full rollover 23:59:59 -> 00:00:00
    do_reset("s3");
    tap_mode();
    tap_inc(23);
    tap_mode();
    tap_inc(59);
    tap_mode();
    tap_inc(59);
    push_exp("s3.preset", 59, 59, 23, BLANK_NONE);
    pop_cmp();
    key_mode = 1'b1;
    step(3);
    key_mode = 1'b0;
    step(9);
    check("s3.tick", 32'(tick_1hz), 32'd1);
    check("s3.sec_hold", 32'(sec), 32'd59);
    push_exp("s3.rollover", 0, 0, 0, BLANK_NONE);
    step(1);
    pop_cmp();

    // SET_MIN wrap without carry; update edge forces blank visible
    do_reset("s4");
    tap_mode();
    tap_inc(5);
    tap_mode();
    tap_inc(59);
    push_exp("s4.preset", 0, 59, 5, BLANK_NONE);
    pop_cmp();
    key_inc = 1'b1;
    step(2);
    push_exp("s4.before_update", 0, 59, 5, BLANK_MIN);
    pop_cmp();
    push_exp("s4.min_wrap", 0, 0, 5, BLANK_NONE);
    step(1);
    pop_cmp();
    drive_keys(1'b0, 1'b0);

    // Simultaneous edges and held key
    do_reset("s5");
    tap_mode();
    tap_inc(3);
    key_mode = 1'b1;
    key_inc  = 1'b1;
    step(3);
    push_exp("s5.mode_wins", 0, 0, 3, BLANK_NONE);
    pop_cmp();
    step(5);
    check("s5.now_set_min", 32'(blank_sel), 32'(BLANK_MIN));
    drive_keys(1'b0, 1'b0);
    key_inc = 1'b1;
    step(20);
    key_inc = 1'b0;
    step(3);
    push_exp("s5.held_once", 0, 1, 3, BLANK_NONE);
    pop_cmp();

    // Reset mid-SET, then RUN ignores inc and counts from zero
    do_reset("s6a");
    tap_mode();
    tap_inc(12);
    tap_mode();
    tap_inc(34);
    tap_mode();
    tap_inc(56);
    tap_mode();
    tap_mode();
    tap_mode();
    push_exp("s6.preset", 56, 34, 12, BLANK_NONE);
    pop_cmp();
    do_reset("s6b");
    key_inc = 1'b1;
    step(3);
    push_exp("s6.inc_ignored", 0, 0, 0, BLANK_NONE);
    pop_cmp();
    key_inc = 1'b0;
    step(3);
    step(3);
    check("s6.tick", 32'(tick_1hz), 32'd1);
    push_exp("s6.resume", 1, 0, 0, BLANK_NONE);
    step(1);
    pop_cmp();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
